// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state type, default slot size and bit-index width helper for the I2S transmitter
package i2s_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int DEF_SLOT = 32;

   function automatic int idx_w(input int slot_w);
      return $clog2(2 * slot_w);
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: SCK divider, falling-edge strobe, frame bit counter and run/idle control
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int SLOT_WIDTH = DEF_SLOT,
   parameter int SCK_HALF   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   output logic                         sck,
   output logic                         fall,
   output logic                         frame,
   output logic [idx_w(SLOT_WIDTH)-1:0] bnext
);

   localparam int L  = 2 * SLOT_WIDTH;
   localparam int IW = idx_w(SLOT_WIDTH);
   localparam int DW = $clog2(SCK_HALF + 1);

   state_t        state, state_n;
   logic [DW-1:0] div_cnt;
   logic [IW-1:0] bit_cnt;
   logic          wrap;

   // en only matters when leaving IDLE or on a frame boundary
   always_comb begin
      wrap    = state == RUN && div_cnt == DW'(SCK_HALF - 1);
      fall    = wrap && sck;
      bnext   = bit_cnt == IW'(L - 1) ? '0 : bit_cnt + 1'b1;
      frame   = fall && bnext == '0;
      state_n = state == IDLE ? (en ? RUN : IDLE) : (frame && !en ? IDLE : RUN);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         sck     <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE) begin
            div_cnt <= '0;
            bit_cnt <= IW'(L - 1);
            sck     <= 1'b0;
         end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) sck <= ~sck;
            if (fall) bit_cnt <= bnext;
         end
      end

endmodule

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: Philips I2S master transmitter with a one-frame valid/ready holding register
module i2s_master_tx
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SLOT_WIDTH = DEF_SLOT,
   parameter int SCK_HALF   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] ldata,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic                  sck,
   output logic                  ws,
   output logic                  sda,
   output logic                  frame_start,
   output logic                  underrun
);

   localparam int L  = 2 * SLOT_WIDTH;
   localparam int IW = idx_w(SLOT_WIDTH);

   logic                  fall, frame, full, acc, load, ws_n;
   logic [IW-1:0]         bnext;
   logic [DATA_WIDTH-1:0] hold_l, hold_r;
   logic [L-1:0]          sh, ld_val;

   i2s_clk_gen #(
      .SLOT_WIDTH(SLOT_WIDTH),
      .SCK_HALF  (SCK_HALF)
   ) u_clk (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sck  (sck),
      .fall (fall),
      .frame(frame),
      .bnext(bnext)
   );

   // ws announces the channel of the following bit, so it leads each MSB by one SCK
   always_comb begin
      in_rdy = !full;
      acc    = in_vld && !full;
      load   = frame && en;
      ws_n   = bnext >= IW'(SLOT_WIDTH - 1) && bnext != IW'(L - 1);
      ld_val = full ? (L'(hold_l) << (L - DATA_WIDTH)) | (L'(hold_r) << (SLOT_WIDTH - DATA_WIDTH)) : '0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         full   <= 1'b0;
         hold_l <= '0;
         hold_r <= '0;
      end else if (acc) begin
         hold_l <= ldata;
         hold_r <= rdata;
         full   <= 1'b1;
      end else if (load) begin
         full <= 1'b0;
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sh          <= '0;
         sda         <= 1'b0;
         ws          <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= load;
         underrun    <= load && !full;
         if (load) begin
            sh  <= ld_val << 1;
            sda <= ld_val[L-1];
            ws  <= ws_n;
         end else if (frame) begin
            sh  <= '0;
            sda <= 1'b0;
            ws  <= 1'b0;
         end else if (fall) begin
            sh  <= sh << 1;
            sda <= sh[L-1];
            ws  <= ws_n;
         end
      end

endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: directed vector bench for the I2S master transmitter (16-bit data, 32-bit slots, SCK_HALF=2)
module tb_i2s_master_tx;

   localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic [63:0] exp;
   } vec_t;

   logic        clk, rst, en, in_vld;
   logic [15:0] ldata, rdata;
   logic        in_rdy, sck, ws, sda, frame_start, underrun;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   i2s_master_tx #(
      .DATA_WIDTH(16),
      .SLOT_WIDTH(32),
      .SCK_HALF  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .ldata      (ldata),
      .rdata      (rdata),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .sck        (sck),
      .ws         (ws),
      .sda        (sda),
      .frame_start(frame_start),
      .underrun   (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_frame(output int n_acc);
      logic ok;
      ok = 1'b0;
      n_acc = 0;
      for (int n = 0; n < 600; n++) begin
         tick;
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
         if (in_rdy && in_vld) n_acc++;
      end
      chk("frame_start seen", 64'(ok), 64'd1);
   endtask

   // records sda/ws at each SCK rising edge, MSB-first into bit 63-b
   task automatic frame_chk(input string nm, input logic [63:0] exp);
      logic [63:0] sv, wv;
      logic        ok;
      ok = 1'b1;
      for (int b = 0; b < 64; b++) begin
         for (int n = 0; n < 16 && !sck; n++) tick;
         if (!sck) ok = 1'b0;
         sv[63-b] = sda;
         wv[63-b] = ws;
         if (b < 63) begin
            for (int n = 0; n < 16 && sck; n++) tick;
            if (sck) ok = 1'b0;
         end
      end
      chk({nm, " sck toggling"}, 64'(ok), 64'd1);
      chk({nm, " sda"}, sv, exp);
      chk({nm, " ws"}, wv, WS_EXP);
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      logic ok;
      ok = 1'b0;
      ldata = l;
      rdata = r;
      in_vld = 1'b1;
      for (int n = 0; n < 600; n++) begin
         if (in_rdy) begin
            ok = 1'b1;
            tick;
            break;
         end
         tick;
      end
      in_vld = 1'b0;
      chk("send accepted", 64'(ok), 64'd1);
   endtask

   initial begin
      vec_t tbl[5];
      int   nr, acc_t, n, fs_cnt, hi_cnt;
      tbl[0] = '{16'h0001, 16'h8001, 64'h0001_0000_8001_0000};
      tbl[1] = '{16'h0002, 16'h8002, 64'h0002_0000_8002_0000};
      tbl[2] = '{16'h0003, 16'h8003, 64'h0003_0000_8003_0000};
      tbl[3] = '{16'h0004, 16'h8004, 64'h0004_0000_8004_0000};
      tbl[4] = '{16'hA5C3, 16'h0F0F, 64'hA5C3_0000_0F0F_0000};
      rst = 1'b1;
      en = 1'b0;
      in_vld = 1'b0;
      ldata = '0;
      rdata = '0;
      repeat (3) tick;
      chk("reset sck", 64'(sck), 64'd0);
      chk("reset ws", 64'(ws), 64'd0);
      chk("reset sda", 64'(sda), 64'd0);
      chk("reset in_rdy", 64'(in_rdy), 64'd1);
      chk("reset frame_start", 64'(frame_start), 64'd0);
      chk("reset underrun", 64'(underrun), 64'd0);
      rst = 1'b0;
      en = 1'b1;
      // first frame with no input underruns and is silent
      wait_frame(nr);
      chk("first frame underrun", 64'(underrun), 64'd1);
      frame_chk("empty frame", 64'd0);
      n = 0;
      do begin tick; n++; end while (sck && n < 16);
      do begin tick; n++; end while (!sck && n < 32);
      chk("sck period", 64'(n), 64'd4);
      // continuous streaming from the vector table
      wait_frame(nr);
      chk("pre-stream underrun", 64'(underrun), 64'd1);
      ldata = tbl[0].l;
      rdata = tbl[0].r;
      in_vld = 1'b1;
      acc_t = cyc;
      tick;
      ldata = tbl[1].l;
      rdata = tbl[1].r;
      for (int i = 0; i < 5; i++) begin
         wait_frame(nr);
         chk("stream extra accepts", 64'(nr), 64'd0);
         chk("stream underrun", 64'(underrun), 64'd0);
         chk("stream in_rdy at frame_start", 64'(in_rdy), 64'd1);
         if (in_vld) begin
            chk("accept interval", 64'(cyc - acc_t), 64'd256);
            acc_t = cyc;
            tick;
            chk("in_rdy after accept", 64'(in_rdy), 64'd0);
            if (i + 2 < 5) begin
               ldata = tbl[i+2].l;
               rdata = tbl[i+2].r;
            end else in_vld = 1'b0;
         end
         frame_chk("stream frame", tbl[i].exp);
      end
      // sample first offered in an underrunning frame_start cycle
      wait_frame(nr);
      chk("late underrun", 64'(underrun), 64'd1);
      ldata = 16'hBEEF;
      rdata = 16'hCAFE;
      in_vld = 1'b1;
      tick;
      in_vld = 1'b0;
      chk("late in_rdy", 64'(in_rdy), 64'd0);
      frame_chk("late current frame", 64'd0);
      wait_frame(nr);
      chk("late next underrun", 64'(underrun), 64'd0);
      frame_chk("late next frame", 64'hBEEF_0000_CAFE_0000);
      // en dropped mid-frame: frame completes, then idle
      wait_frame(nr);
      send(16'h1357, 16'h2468);
      wait_frame(nr);
      en = 1'b0;
      frame_chk("en drop frame", 64'h1357_0000_2468_0000);
      tick;
      tick;
      fs_cnt = 0;
      hi_cnt = 0;
      for (int k = 0; k < 300; k++) begin
         tick;
         fs_cnt += int'(frame_start);
         hi_cnt += int'(sck | ws | sda);
      end
      chk("idle frame_start", 64'(fs_cnt), 64'd0);
      chk("idle outputs", 64'(hi_cnt), 64'd0);
      send(16'hABCD, 16'h0123);
      en = 1'b1;
      wait_frame(nr);
      chk("reenable underrun", 64'(underrun), 64'd0);
      frame_chk("reenable frame", 64'hABCD_0000_0123_0000);
      // asynchronous reset in the right slot drops the pending sample
      wait_frame(nr);
      send(16'h5555, 16'h6666);
      for (int k = 0; k < 300 && !ws; k++) tick;
      repeat (40) tick;
      chk("pre-reset ws", 64'(ws), 64'd1);
      chk("pre-reset in_rdy", 64'(in_rdy), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async reset sck", 64'(sck), 64'd0);
      chk("async reset ws", 64'(ws), 64'd0);
      chk("async reset sda", 64'(sda), 64'd0);
      chk("async reset in_rdy", 64'(in_rdy), 64'd1);
      chk("async reset frame_start", 64'(frame_start), 64'd0);
      chk("async reset underrun", 64'(underrun), 64'd0);
      tick;
      tick;
      rst = 1'b0;
      wait_frame(nr);
      chk("post-reset underrun", 64'(underrun), 64'd1);
      frame_chk("post-reset frame", 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
